// File: rtl/ecc_scrubber.sv
// ECC scrubber: walks a SECDED-protected bank one word per trigger and writes back single-bit fixes.
// Event counters exist only when ECC_SCRUB_STATS_EN is defined; otherwise the counter ports read 0.

package ecc_pkg;
    function automatic int get_cw_width(input int data_width);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if (r == 0 && (1 << i) >= data_width + i + 1) r = i;
        end
        return data_width + r + 1;
    endfunction
endpackage

module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int BankSize  = 256,
    parameter int DataWidth = 64,
    localparam int EW = get_cw_width(DataWidth),
    localparam int AW = $clog2(BankSize)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scrub_trigger_i,
    input  logic          intc_req_i,
    output logic          bank_req_o,
    output logic          bank_we_o,
    output logic [AW-1:0] bank_add_o,
    output logic [EW-1:0] bank_wdata_o,
    input  logic [EW-1:0] bank_rdata_i,
    output logic [31:0]   nb_corrected_o,
    output logic [31:0]   nb_uncorrectable_o
);

    localparam int PB = EW - DataWidth - 1;

    // state | meaning
    // IDLE  | waiting for a scrub trigger
    // READ  | issuing the read of the current address
    // CHECK | decoding the word returned by the bank
    // WRITE | writing the corrected word back
    typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [EW-1:0] r_corr;

    logic [PB-1:0] w_syn;
    logic          w_ovr;
    logic          w_err;
    logic          w_uncorr;
    logic [EW-1:0] w_repair;
    logic          w_req;
    logic          w_we;
    logic          w_adv;
    logic          w_latch;

    function automatic logic [EW-1:0] encode(input logic [DataWidth-1:0] data);
        logic [EW-1:0] cw;
        logic          par;
        int            j;
        cw = '0;
        j  = 0;
        for (int p = 0; p < EW - 1; p++) begin
            if (((p + 1) & p) != 0) begin
                cw[p] = data[j];
                j++;
            end
        end
        for (int i = 0; i < PB; i++) begin
            par = 1'b0;
            for (int p = 0; p < EW - 1; p++) begin
                if ((((p + 1) >> i) & 1) != 0) par = par ^ cw[p];
            end
            cw[(1 << i) - 1] = par;
        end
        cw[EW-1] = ^cw[EW-2:0];
        return cw;
    endfunction

    function automatic logic [PB-1:0] syndrome(input logic [EW-2:0] cw);
        logic [PB-1:0] s;
        s = '0;
        for (int i = 0; i < PB; i++) begin
            for (int p = 0; p < EW - 1; p++) begin
                if ((((p + 1) >> i) & 1) != 0) s[i] = s[i] ^ cw[p];
            end
        end
        return s;
    endfunction

    // Flip the bit the syndrome points at, then rebuild every check bit from the data.
    function automatic logic [EW-1:0] repair(input logic [EW-2:0] cw, input logic [PB-1:0] syn);
        logic [EW-2:0]        fixed;
        logic [DataWidth-1:0] data;
        int                   j;
        fixed = cw;
        for (int p = 0; p < EW - 1; p++) begin
            if (p + 1 == int'(syn)) fixed[p] = ~fixed[p];
        end
        data = '0;
        j    = 0;
        for (int p = 0; p < EW - 1; p++) begin
            if (((p + 1) & p) != 0) begin
                data[j] = fixed[p];
                j++;
            end
        end
        return encode(data);
    endfunction

    // Odd overall parity with a zero syndrome is a flipped MSB; repair() regenerates it.
    always_comb begin
        w_syn    = syndrome(bank_rdata_i[EW-2:0]);
        w_ovr    = ^bank_rdata_i;
        w_err    = w_ovr || (w_syn != '0);
        w_uncorr = (!w_ovr && (w_syn != '0)) || (w_ovr && (int'(w_syn) > EW - 1));
        w_repair = repair(bank_rdata_i[EW-2:0], w_syn);
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_adv   = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            IDLE: begin
                if (scrub_trigger_i) w_next = READ;
            end
            READ: begin
                if (!intc_req_i) begin
                    w_req  = 1'b1;
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (intc_req_i) begin
                    w_next = READ;
                end else if (w_uncorr) begin
                    w_adv  = 1'b1;
                    w_next = IDLE;
                end else if (w_err) begin
                    w_latch = 1'b1;
                    w_next  = WRITE;
                end else begin
                    w_adv  = 1'b1;
                    w_next = IDLE;
                end
            end
            WRITE: begin
                if (intc_req_i) begin
                    w_next = READ;
                end else begin
                    w_req  = 1'b1;
                    w_we   = 1'b1;
                    w_adv  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_corr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_adv) r_addr <= r_addr + AW'(1);
            if (w_latch) r_corr <= w_repair;
        end
    end

    // Gating with reset keeps a scrub caught mid-write from reaching the bank.
    assign bank_req_o   = w_req && !rst_i;
    assign bank_we_o    = w_we && !rst_i;
    assign bank_wdata_o = bank_we_o ? r_corr : '0;
    assign bank_add_o   = r_addr;

`ifdef ECC_SCRUB_STATS_EN
    logic [31:0] r_nb_corr;
    logic [31:0] r_nb_unc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_nb_corr <= '0;
            r_nb_unc  <= '0;
        end else begin
            if (w_we && (r_nb_corr != '1)) r_nb_corr <= r_nb_corr + 32'd1;
            if ((r_state == CHECK) && !intc_req_i && w_uncorr && (r_nb_unc != '1))
                r_nb_unc <= r_nb_unc + 32'd1;
        end
    end

    assign nb_corrected_o     = r_nb_corr;
    assign nb_uncorrectable_o = r_nb_unc;
`else
    assign nb_corrected_o     = '0;
    assign nb_uncorrectable_o = '0;
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: a queue of expected bank transactions (with cycle stamps)
// is checked by a monitor against every bank request the DUT issues.

module tb_ecc_scrubber;
    localparam int EW = 39;
`ifdef ECC_SCRUB_STATS_EN
    localparam int Stats = 1;
`else
    localparam int Stats = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          scrub_trigger_i;
    logic          intc_req_i;
    logic          bank_req_o;
    logic          bank_we_o;
    logic [7:0]    bank_add_o;
    logic [EW-1:0] bank_wdata_o;
    logic [EW-1:0] bank_rdata_i;
    logic [31:0]   nb_corrected_o;
    logic [31:0]   nb_uncorrectable_o;

    typedef struct {
        logic          we;
        logic [7:0]    addr;
        logic [EW-1:0] data;
        int            cyc;
    } txn_t;

    txn_t          sb[$];
    logic [EW-1:0] mem[256];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [7:0]    exp_addr;

    ecc_scrubber #(.BankSize(256), .DataWidth(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .scrub_trigger_i    (scrub_trigger_i),
        .intc_req_i         (intc_req_i),
        .bank_req_o         (bank_req_o),
        .bank_we_o          (bank_we_o),
        .bank_add_o         (bank_add_o),
        .bank_wdata_o       (bank_wdata_o),
        .bank_rdata_i       (bank_rdata_i),
        .nb_corrected_o     (nb_corrected_o),
        .nb_uncorrectable_o (nb_uncorrectable_o)
    );

    always #5 clk_i = ~clk_i;

    // Bank model: read data appears one cycle after the read request.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (bank_req_o && !bank_we_o) bank_rdata_i <= mem[bank_add_o];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] cnt(input int n);
        return (Stats != 0) ? 64'(n) : 64'd0;
    endfunction

    task automatic push(input logic we, input logic [7:0] a, input logic [EW-1:0] d, input int c);
        txn_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic monitor();
        txn_t e;
        forever begin
            @(negedge clk_i);
            chk("req_while_intc", 64'(bank_req_o & intc_req_i), 64'd0);
            if (!bank_req_o) chk("quiet_outputs", 64'({bank_we_o, bank_wdata_o}), 64'd0);
            if (bank_req_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got we=%0b addr=%0d at cycle %0d, required none",
                             bank_we_o, bank_add_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("txn_we", 64'(bank_we_o), 64'(e.we));
                    chk("txn_addr", 64'(bank_add_o), 64'(e.addr));
                    chk("txn_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.we) chk("txn_wdata", 64'(bank_wdata_o), 64'(e.data));
                end
            end
        end
    endtask

    task automatic check_state(input string tag, input int corr, input int unc);
        chk({tag, "_addr"}, 64'(bank_add_o), 64'(exp_addr));
        chk({tag, "_corr"}, 64'(nb_corrected_o), cnt(corr));
        chk({tag, "_unc"}, 64'(nb_uncorrectable_o), cnt(unc));
    endtask

    // Trigger at T, read at T+1, optional write-back at T+3; extra_trig re-pulses during CHECK.
    task automatic scrub(input logic wr, input logic [EW-1:0] wd, input logic extra_trig);
        int t;
        t = cyc;
        push(1'b0, exp_addr, '0, t + 1);
        if (wr) push(1'b1, exp_addr, wd, t + 3);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        scrub_trigger_i = extra_trig;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        exp_addr = exp_addr + 8'd1;
    endtask

    initial begin
        int t;
        rst_i           = 1'b1;
        scrub_trigger_i = 1'b0;
        intc_req_i      = 1'b0;
        exp_addr        = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        check_state("reset", 0, 0);
        chk("reset_req", 64'(bank_req_o), 64'd0);

        // Clean word (data 1) at address 0.
        mem[0] = 39'h40_0000_0007;
        scrub(1'b0, '0, 1'b0);
        check_state("clean0", 0, 0);

        for (int i = 1; i < 5; i++) scrub(1'b0, '0, (i == 2));

        // Data 0x8000_0011 with bit 2 flipped at address 5.
        mem[5] = 39'h20_8000_0188;
        scrub(1'b1, 39'h20_8000_018C, 1'b0);
        mem[5] = 39'h20_8000_018C;
        check_state("single5", 1, 0);

        scrub(1'b0, '0, 1'b0);

        // Data 0x8000_0000 with bits 3 and 10 flipped at address 7.
        mem[7] = 39'h20_8000_0402;
        scrub(1'b0, '0, 1'b0);
        check_state("double7", 1, 1);

        // Overall-parity bit flipped at address 8.
        mem[8] = 39'h00_0000_0007;
        scrub(1'b1, 39'h40_0000_0007, 1'b0);
        mem[8] = 39'h40_0000_0007;
        check_state("ovr8", 2, 1);

        // Data 0x10 with bit 20 flipped; interconnect steals the WRITE cycle.
        mem[9] = 39'h40_0010_0181;
        t = cyc;
        push(1'b0, 8'd9, '0, t + 1);
        push(1'b0, 8'd9, '0, t + 6);
        push(1'b1, 8'd9, 39'h40_0000_0181, t + 8);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        tick();
        intc_req_i = 1'b1;
        repeat (3) tick();
        intc_req_i = 1'b0;
        repeat (3) tick();
        mem[9] = 39'h40_0000_0181;
        exp_addr = exp_addr + 8'd1;
        check_state("intc_write9", 3, 1);

        // Data 1 with bit 0 flipped; interconnect steals the CHECK cycle.
        mem[10] = 39'h40_0000_0006;
        t = cyc;
        push(1'b0, 8'd10, '0, t + 1);
        push(1'b0, 8'd10, '0, t + 4);
        push(1'b1, 8'd10, 39'h40_0000_0007, t + 6);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        intc_req_i = 1'b1;
        repeat (2) tick();
        intc_req_i = 1'b0;
        repeat (3) tick();
        mem[10] = 39'h40_0000_0007;
        exp_addr = exp_addr + 8'd1;
        check_state("intc_check10", 4, 1);

        // Finish the lap, then one full lap of clean scrubs must land back at 0.
        mem[7] = 39'h20_8000_000A;
        for (int i = 11; i < 256; i++) scrub(1'b0, '0, (i % 3 == 0));
        check_state("wrap1", 4, 1);
        for (int i = 0; i < 256; i++) scrub(1'b0, '0, (i % 5 == 1));
        check_state("wrap2", 4, 1);

        // Reset while in WRITE: no write-back, everything cleared.
        mem[0] = 39'h40_0000_0003;
        t = cyc;
        push(1'b0, 8'd0, '0, t + 1);
        scrub_trigger_i = 1'b1;
        tick();
        scrub_trigger_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        exp_addr = 8'd0;
        check_state("rst_write", 0, 0);
        chk("rst_write_req", 64'(bank_req_o), 64'd0);
        chk("rst_write_we", 64'(bank_we_o), 64'd0);
        chk("rst_write_wdata", 64'(bank_wdata_o), 64'd0);
        repeat (4) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
